// File: rtl/lzc_norm_pipe.sv
// Leading-zero count and left-normalise of a tagged operand, valid/ready on both sides.
// Latency 1 cycle; 2 cycles when LZC_NORM_OUTREG_EN adds an output register stage.
// Backpressure: a stage holds while downstream stalls; in_ready drops only when every stage is full and stuck.
module lzc_norm_pipe #(
   parameter int XLEN = 32,
   parameter int XLOG = 5,
   parameter int TAGW = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_a,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLOG-1:0] out_cnt,
   output logic            out_zero,
   output logic [XLEN-1:0] out_norm,
   output logic [TAGW-1:0] out_tag
);

   logic [XLOG-1:0] lz_cnt;
   logic            lz_zero;
   logic [XLEN-1:0] lz_norm;

   // Ascending scan: the last set bit seen is the highest one, so it decides the count.
   always_comb begin
      lz_cnt  = '0;
      lz_zero = (in_a == '0);
      for (int i = 0; i < XLEN; i++) begin
         if (in_a[i]) lz_cnt = XLOG'(XLEN - 1 - i);
      end
      lz_norm = in_a << lz_cnt;
   end

   logic            s1_vld;
   logic            s1_adv;
   logic            in_xfer;
   logic [XLOG-1:0] s1_cnt;
   logic            s1_zero;
   logic [XLEN-1:0] s1_norm;
   logic [TAGW-1:0] s1_tag;

   assign in_ready = reset & (~s1_vld | s1_adv);
   assign in_xfer  = in_valid & in_ready;

   // Data only moves on a real transfer so idle outputs keep the last delivered result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_vld  <= 1'b0;
         s1_cnt  <= '0;
         s1_zero <= 1'b0;
         s1_norm <= '0;
         s1_tag  <= '0;
      end else begin
         if (in_ready) s1_vld <= in_valid;
         if (in_xfer) begin
            s1_cnt  <= lz_cnt;
            s1_zero <= lz_zero;
            s1_norm <= lz_norm;
            s1_tag  <= in_tag;
         end
      end
   end

`ifdef LZC_NORM_OUTREG_EN
   logic            s2_vld;
   logic [XLOG-1:0] s2_cnt;
   logic            s2_zero;
   logic [XLEN-1:0] s2_norm;
   logic [TAGW-1:0] s2_tag;

   assign s1_adv = ~s2_vld | out_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s2_vld  <= 1'b0;
         s2_cnt  <= '0;
         s2_zero <= 1'b0;
         s2_norm <= '0;
         s2_tag  <= '0;
      end else begin
         if (s1_adv) s2_vld <= s1_vld;
         if (s1_vld & s1_adv) begin
            s2_cnt  <= s1_cnt;
            s2_zero <= s1_zero;
            s2_norm <= s1_norm;
            s2_tag  <= s1_tag;
         end
      end
   end

   assign out_valid = s2_vld;
   assign out_cnt   = s2_cnt;
   assign out_zero  = s2_zero;
   assign out_norm  = s2_norm;
   assign out_tag   = s2_tag;
`else
   assign s1_adv    = out_ready;
   assign out_valid = s1_vld;
   assign out_cnt   = s1_cnt;
   assign out_zero  = s1_zero;
   assign out_norm  = s1_norm;
   assign out_tag   = s1_tag;
`endif

endmodule
